// File: rtl/bcd_to_bin_seq_if.sv
// Handshake/data bundle for the sequential BCD-to-binary converter.
interface bcd_to_bin_seq_if #(
    parameter int unsigned NR_CIFRE   = 2,
    parameter int unsigned LATIME_BIN = 7
) ();
    logic                    start;
    logic [4*NR_CIFRE-1:0]   bcd_in;
    logic                    busy;
    logic                    done;
    logic [LATIME_BIN-1:0]   valoare_bin;
    logic                    eroare;

    modport master (
        output start, bcd_in,
        input  busy, done, valoare_bin, eroare
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, valoare_bin, eroare
    );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per clock).
// Optional invalid-digit check enabled by defining VALIDARE_BCD_EN.
module bcd_to_bin_seq #(
    parameter int unsigned NR_CIFRE   = 2,
    parameter int unsigned LATIME_BIN = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_to_bin_seq_if.slave   bus
);
    localparam int unsigned BCD_W = 4 * NR_CIFRE;
    localparam int unsigned SR_W  = BCD_W + LATIME_BIN;
    localparam int unsigned CNT_W = $clog2(LATIME_BIN + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state_q, state_nx;
    logic [BCD_W-1:0]      bcd_q;
    logic [LATIME_BIN-1:0] bin_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  busy_q, done_q;
    logic [LATIME_BIN-1:0] val_q;

    logic                  load_c, shift_c, publish_c, last_c;
    logic                  busy_nx;
    logic [SR_W-1:0]       shifted_c;
    logic [BCD_W-1:0]      bcd_corr_c;

    assign last_c = (cnt_q == CNT_W'(LATIME_BIN - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_nx = SHIFT;
            SHIFT:   if (last_c)    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output/control decode; busy is registered from the next state
    always_comb begin
        load_c    = (state_q == IDLE) && bus.start;
        shift_c   = (state_q == SHIFT);
        publish_c = (state_q == DONE);
        busy_nx   = (state_nx == SHIFT);
    end

    // Shift right by one, then subtract 3 from every digit that landed at >= 8
    always_comb begin
        shifted_c  = {bcd_q, bin_q} >> 1;
        bcd_corr_c = shifted_c[SR_W-1 -: BCD_W];
        for (int unsigned i = 0; i < NR_CIFRE; i++) begin
            if (bcd_corr_c[4*i +: 4] >= 4'd8)
                bcd_corr_c[4*i +: 4] = bcd_corr_c[4*i +: 4] - 4'd3;
        end
    end

`ifdef VALIDARE_BCD_EN
    logic err_in_c, err_cap_q, err_q;

    always_comb begin
        err_in_c = 1'b0;
        for (int unsigned i = 0; i < NR_CIFRE; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) err_in_c = 1'b1;
        end
    end

    // Validity flag captured at load, published with done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cap_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (load_c)    err_cap_q <= err_in_c;
            if (publish_c) err_q     <= err_cap_q;
        end
    end

    assign bus.eroare = err_q;
`else
    assign bus.eroare = 1'b0;
`endif

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q  <= '0;
            bin_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            val_q  <= '0;
        end else begin
            busy_q <= busy_nx;
            done_q <= publish_c;
            if (load_c) begin
                bcd_q <= bus.bcd_in;
                bin_q <= '0;
                cnt_q <= '0;
            end else if (shift_c) begin
                bcd_q <= bcd_corr_c;
                bin_q <= shifted_c[LATIME_BIN-1:0];
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (publish_c) begin
`ifdef VALIDARE_BCD_EN
                val_q <= err_cap_q ? '0 : bin_q;
`else
                val_q <= bin_q;
`endif
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.valoare_bin = val_q;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq (2-digit and 3-digit instances).
module tb_bcd_to_bin_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_to_bin_seq_if #(.NR_CIFRE(2), .LATIME_BIN(7))  b2 ();
    bcd_to_bin_seq_if #(.NR_CIFRE(3), .LATIME_BIN(10)) b3 ();

    bcd_to_bin_seq #(.NR_CIFRE(2), .LATIME_BIN(7)) dut (
        .clk(clk), .rst_n(rst_n), .bus(b2.slave));
    bcd_to_bin_seq #(.NR_CIFRE(3), .LATIME_BIN(10)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(b3.slave));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start one 2-digit conversion; lat counts edges from the start edge to done
    task automatic run2(input logic [7:0] bcd, output int lat, output int bcnt,
                        output logic [31:0] val, output logic err, output logic done_next);
        @(negedge clk);
        b2.bcd_in = bcd;
        b2.start  = 1'b1;
        @(posedge clk); #1;
        b2.start = 1'b0;
        bcnt = (b2.busy === 1'b1) ? 1 : 0;
        lat  = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (b2.done === 1'b1) begin
                lat = n;
                break;
            end
            if (b2.busy === 1'b1) bcnt++;
        end
        val = 32'(b2.valoare_bin);
        err = b2.eroare;
        @(posedge clk); #1;
        done_next = b2.done;
    endtask

    task automatic run3(input logic [11:0] bcd, output int lat, output logic [31:0] val);
        @(negedge clk);
        b3.bcd_in = bcd;
        b3.start  = 1'b1;
        @(posedge clk); #1;
        b3.start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (b3.done === 1'b1) begin
                lat = n;
                break;
            end
        end
        val = 32'(b3.valoare_bin);
        @(posedge clk); #1;
    endtask

    initial begin
        int          lat, bcnt, nd, ndone;
        logic [31:0] val;
        logic        err, dn;
        int          de[3];
        logic [31:0] dv[3];

        b2.start = 1'b0; b2.bcd_in = '0;
        b3.start = 1'b0; b3.bcd_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  32'(b2.busy), 32'd0);
        check("rst_done",  32'(b2.done), 32'd0);
        check("rst_val",   32'(b2.valoare_bin), 32'd0);
        check("rst_err",   32'(b2.eroare), 32'd0);
        rst_n = 1'b1;

        run2(8'h00, lat, bcnt, val, err, dn);
        check("lat_00",  32'(lat), 32'd8);
        check("busy_00", 32'(bcnt), 32'd7);
        check("val_00",  val, 32'd0);
        check("err_00",  32'(err), 32'd0);
        check("pulse_00", 32'(dn), 32'd0);

        run2(8'h59, lat, bcnt, val, err, dn);
        check("val_59", val, 32'd59);
        check("lat_59", 32'(lat), 32'd8);
        check("pulse_59", 32'(dn), 32'd0);

        run2(8'h99, lat, bcnt, val, err, dn);
        check("val_99", val, 32'd99);
        check("busy_99", 32'(bcnt), 32'd7);
        check("pulse_99", 32'(dn), 32'd0);

        run2(8'h10, lat, bcnt, val, err, dn);
        check("val_10", val, 32'd10);
        check("pulse_10", 32'(dn), 32'd0);

        // start held high: conversions every 9 cycles, bcd_in change mid-SHIFT
        for (int i = 0; i < 3; i++) begin de[i] = 0; dv[i] = '0; end
        nd = 0;
        @(negedge clk);
        b2.bcd_in = 8'h37;
        b2.start  = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (e == 13) b2.bcd_in = 8'h42;
            if (b2.done === 1'b1) begin
                de[nd] = e;
                dv[nd] = 32'(b2.valoare_bin);
                nd++;
                if (nd == 3) begin
                    b2.start = 1'b0;
                    break;
                end
            end
        end
        b2.start = 1'b0;
        check("cont_t0", 32'(de[0]), 32'd9);
        check("cont_t1", 32'(de[1]), 32'd18);
        check("cont_t2", 32'(de[2]), 32'd27);
        check("cont_v0", dv[0], 32'd37);
        check("cont_v1", dv[1], 32'd37);
        check("cont_v2", dv[2], 32'd42);
        repeat (3) @(posedge clk);

        // async reset in the 4th SHIFT cycle
        @(negedge clk);
        b2.bcd_in = 8'h45;
        b2.start  = 1'b1;
        @(posedge clk); #1;
        b2.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_pre", 32'(b2.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(b2.busy), 32'd0);
        check("abort_done", 32'(b2.done), 32'd0);
        check("abort_val",  32'(b2.valoare_bin), 32'd0);
        check("abort_err",  32'(b2.eroare), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (b2.done !== 1'b0) ndone++;
        end
        check("abort_nodone", 32'(ndone), 32'd0);
        run2(8'h45, lat, bcnt, val, err, dn);
        check("val_45", val, 32'd45);
        check("lat_45", 32'(lat), 32'd8);

        // invalid digit, then a valid one
        run2(8'h3A, lat, bcnt, val, err, dn);
`ifdef VALIDARE_BCD_EN
        check("err_3A", 32'(err), 32'd1);
        check("val_3A", val, 32'd0);
`else
        check("err_3A", 32'(err), 32'd0);
`endif
        check("lat_3A", 32'(lat), 32'd8);
        run2(8'h12, lat, bcnt, val, err, dn);
        check("err_12", 32'(err), 32'd0);
        check("val_12", val, 32'd12);

        // three-digit instance
        run3(12'h999, lat, val);
        check("lat3_999", 32'(lat), 32'd11);
        check("val3_999", val, 32'd999);
        run3(12'h305, lat, val);
        check("val3_305", val, 32'd305);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
